exception_controller: RTL and testbench
=======================================

EXCEPTION_CONTROLLER -- requirements
Module: exception_controller

Interface
REQ-001 Parameter HANDLER_PC, default 32'h0000_2000: supervisor handler entry address.
REQ-002 Parameter WORD_SIZE, default 32: width of PC, address and rm registers.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 in_commit_valid  in  1  an instruction retires this cycle.
REQ-006 in_commit_pc  in  WORD_SIZE  PC of the retiring instruction.
REQ-007 in_commit_instr_type  in  3  decoded instr_type of the retiring instruction.
REQ-008 in_commit_exception_vector  in  3  exception bits carried down the pipe: [2] privileged-op, [1] ITLB miss, [0] DTLB miss.
REQ-009 in_commit_fault_addr  in  WORD_SIZE  faulting virtual data address (DTLB miss).
REQ-010 out_supervisor_mode  out  1  core privilege, fed to decoder in_supervisor_mode.
REQ-011 out_flush  out  1  kill all in-flight instructions younger than commit.
REQ-012 out_redirect_valid  out  1  fetch PC override strobe.
REQ-013 out_redirect_pc  out  WORD_SIZE  fetch override target.
REQ-014 out_rm0 / out_rm1 / out_rm2  out  WORD_SIZE each  saved PC / fault address / cause, read by MOVRM.
REQ-015 out_halted  out  1  core halted on double fault (only with macro, else tied 0).

Function
REQ-016 State machine SHALL have states USER, ENTER, SUPER, RETURN (plus HALT with macro).
REQ-017 USER: commit_valid and vector != 0 -> ENTER; capture rm0=commit_pc, rm2={29'b0,vector}, rm1=fault_addr if vector[0] else commit_pc, all on the same edge.
REQ-018 USER: commit with vector == 0 SHALL not change state or rm registers, including IRET type.
REQ-019 ENTER: out_flush=1, out_redirect_valid=1, out_redirect_pc=HANDLER_PC for exactly one cycle, then -> SUPER unconditionally; commit inputs ignored.
REQ-020 out_supervisor_mode SHALL be 1 in ENTER, SUPER and RETURN, 0 in USER; decoder sees supervisor mode from the cycle after the exception commit.
REQ-021 SUPER: commit_valid with instr_type == INSTR_TYPE_IRET -> RETURN.
REQ-022 RETURN: out_flush=1, out_redirect_valid=1, out_redirect_pc=rm0 for one cycle, then -> USER.
REQ-023 Exception-to-redirect latency SHALL be 1 cycle; IRET-to-redirect latency 1 cycle.
REQ-024 rm0..rm2 SHALL change only on the USER->ENTER edge; MOVRM reads in SUPER see stable values.
REQ-025 SUPER with commit vector != 0 and IRET in the same cycle: exception handling (REQ-030) takes priority over IRET.
REQ-026 out_flush and out_redirect_valid SHALL be 0 in USER and SUPER.

Reset
REQ-027 Reset SHALL force state USER, supervisor_mode=0, flush=0, redirect_valid=0, redirect_pc=0, rm0..rm2=0, halted=0.
REQ-028 Reset asserted during ENTER or RETURN SHALL abort the redirect; no redirect strobe after reset release.

Configuration
REQ-029 Macro DOUBLE_FAULT_HALT_EN selects supervisor-mode exception handling.
REQ-030 With macro: SUPER commit with vector != 0 -> HALT; HALT asserts out_halted=1, out_flush=1 every cycle, exits only via reset; rm registers unchanged.
REQ-031 Without macro: vectors committed in SUPER are ignored; no HALT state; out_halted tied 0.

Structure
REQ-032 State enum, vector bit indices and HANDLER_PC default SHALL live in the shared defines package beside the INSTR_TYPE_* and OPCODE_* constants.
REQ-033 No sub-module; single always_ff FSM plus combinational output decode.

Verification
REQ-034 Privileged op in USER, pc=0x100, vector=3'b100 -> next cycle flush=1, redirect 0x2000, rm0=0x100, rm1=0x100, rm2=4, supervisor_mode=1.
REQ-035 DTLB miss pc=0x204, fault_addr=0x8000_0010, vector=3'b001 -> rm1=0x8000_0010, rm2=1; then IRET in SUPER -> one-cycle redirect to 0x204, USER next cycle.
REQ-036 IRET committed in USER with vector 0 -> no flush, no redirect, rm unchanged.
REQ-037 Vector 3'b010 in SUPER -> with macro out_halted=1 persisting until reset; without macro state stays SUPER, rm unchanged.
REQ-038 Reset asserted in ENTER cycle -> redirect_valid drops immediately, state USER, rm0..rm2=0.

Source files
------------

// File: rtl/exception_controller_pkg.sv
// Shared defines for the exception controller: states, exception vector bits, instr_type/opcode codes.
// DOUBLE_FAULT_HALT_EN adds the HALT state used for double-fault handling.
package exception_controller_pkg;

  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_2000;

  localparam int EXC_PRIV_BIT = 2;
  localparam int EXC_ITLB_BIT = 1;
  localparam int EXC_DTLB_BIT = 0;

  localparam logic [2:0] INSTR_TYPE_ALU    = 3'd0;
  localparam logic [2:0] INSTR_TYPE_LOAD   = 3'd1;
  localparam logic [2:0] INSTR_TYPE_STORE  = 3'd2;
  localparam logic [2:0] INSTR_TYPE_BRANCH = 3'd3;
  localparam logic [2:0] INSTR_TYPE_MOVRM  = 3'd4;
  localparam logic [2:0] INSTR_TYPE_IRET   = 3'd5;

  localparam logic [5:0] OPCODE_MOVRM = 6'h3c;
  localparam logic [5:0] OPCODE_IRET  = 6'h3d;

  typedef enum logic [2:0] {
    ST_USER   = 3'd0,
    ST_ENTER  = 3'd1,
    ST_SUPER  = 3'd2,
    ST_RETURN = 3'd3
`ifdef DOUBLE_FAULT_HALT_EN
    , ST_HALT = 3'd4
`endif
  } exc_state_e;

endpackage

// File: rtl/exception_controller_if.sv
// Commit-side inputs and privilege/redirect outputs of the exception controller.
interface exception_controller_if #(parameter int WORD_SIZE = 32);
  logic                 in_commit_valid;
  logic [WORD_SIZE-1:0] in_commit_pc;
  logic [2:0]           in_commit_instr_type;
  logic [2:0]           in_commit_exception_vector;
  logic [WORD_SIZE-1:0] in_commit_fault_addr;
  logic                 out_supervisor_mode;
  logic                 out_flush;
  logic                 out_redirect_valid;
  logic [WORD_SIZE-1:0] out_redirect_pc;
  logic [WORD_SIZE-1:0] out_rm0;
  logic [WORD_SIZE-1:0] out_rm1;
  logic [WORD_SIZE-1:0] out_rm2;
  logic                 out_halted;

  modport master (
    output in_commit_valid, in_commit_pc, in_commit_instr_type,
           in_commit_exception_vector, in_commit_fault_addr,
    input  out_supervisor_mode, out_flush, out_redirect_valid, out_redirect_pc,
           out_rm0, out_rm1, out_rm2, out_halted
  );

  modport slave (
    input  in_commit_valid, in_commit_pc, in_commit_instr_type,
           in_commit_exception_vector, in_commit_fault_addr,
    output out_supervisor_mode, out_flush, out_redirect_valid, out_redirect_pc,
           out_rm0, out_rm1, out_rm2, out_halted
  );
endinterface

// File: rtl/exception_controller.sv
// Privilege/exception sequencer: traps committed exceptions to HANDLER_PC and returns on IRET.
// DOUBLE_FAULT_HALT_EN: an exception committed in supervisor mode halts the core until reset.
module exception_controller
  import exception_controller_pkg::*;
#(
  parameter int                   WORD_SIZE  = 32,
  parameter logic [WORD_SIZE-1:0] HANDLER_PC = WORD_SIZE'(HANDLER_PC_DEFAULT)
) (
  input logic                    clk,
  input logic                    reset,
  exception_controller_if.slave  bus
);

  exc_state_e           state_q, state_d;
  logic [WORD_SIZE-1:0] rm0_q, rm0_d;
  logic [WORD_SIZE-1:0] rm1_q, rm1_d;
  logic [WORD_SIZE-1:0] rm2_q, rm2_d;

  logic commit_exc;
  logic commit_iret;

  assign commit_exc  = bus.in_commit_valid && (bus.in_commit_exception_vector != 3'b000);
  assign commit_iret = bus.in_commit_valid && (bus.in_commit_instr_type == INSTR_TYPE_IRET);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_USER;
      rm0_q   <= '0;
      rm1_q   <= '0;
      rm2_q   <= '0;
    end else begin
      state_q <= state_d;
      rm0_q   <= rm0_d;
      rm1_q   <= rm1_d;
      rm2_q   <= rm2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rm0_d   = rm0_q;
    rm1_d   = rm1_q;
    rm2_d   = rm2_q;
    case (state_q)
      ST_USER: begin
        // The rm registers are written only on trap entry so handler MOVRM reads stay stable.
        if (commit_exc) begin
          state_d    = ST_ENTER;
          rm0_d      = bus.in_commit_pc;
          rm1_d      = bus.in_commit_exception_vector[EXC_DTLB_BIT] ?
                       bus.in_commit_fault_addr : bus.in_commit_pc;
          rm2_d      = '0;
          rm2_d[2:0] = bus.in_commit_exception_vector;
        end
      end
      ST_ENTER:  state_d = ST_SUPER;
      ST_SUPER: begin
`ifdef DOUBLE_FAULT_HALT_EN
        if (commit_exc) begin
          state_d = ST_HALT;
        end else
`endif
        if (commit_iret) begin
          state_d = ST_RETURN;
        end
      end
      ST_RETURN: state_d = ST_USER;
`ifdef DOUBLE_FAULT_HALT_EN
      ST_HALT:   state_d = ST_HALT;
`endif
      default:   state_d = ST_USER;
    endcase
  end

  logic                 halted;
  logic                 supervisor;
  logic                 flush;
  logic                 redirect_valid;
  logic [WORD_SIZE-1:0] redirect_pc;

  always_comb begin
    supervisor     = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halted         = 1'b0;
    case (state_q)
      ST_ENTER: begin
        supervisor     = 1'b1;
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = HANDLER_PC;
      end
      ST_SUPER:  supervisor = 1'b1;
      ST_RETURN: begin
        supervisor     = 1'b1;
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = rm0_q;
      end
`ifdef DOUBLE_FAULT_HALT_EN
      ST_HALT: begin
        supervisor = 1'b1;
        flush      = 1'b1;
        halted     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.out_supervisor_mode = supervisor;
  assign bus.out_flush           = flush;
  assign bus.out_redirect_valid  = redirect_valid;
  assign bus.out_redirect_pc     = redirect_pc;
  assign bus.out_rm0             = rm0_q;
  assign bus.out_rm1             = rm1_q;
  assign bus.out_rm2             = rm2_q;
  assign bus.out_halted          = halted;

endmodule

// File: tb/tb_exception_controller.sv
// Self-checking bench for exception_controller: directed scenarios plus randomized commits vs. a mode model.
module tb_exception_controller;
  import exception_controller_pkg::*;

  localparam int          W       = 32;
  localparam logic [31:0] HANDLER = 32'h0000_2000;
`ifdef DOUBLE_FAULT_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;
  bit   cmp_en   = 1'b0;

  exception_controller_if #(.WORD_SIZE(W)) bus ();

  exception_controller #(.WORD_SIZE(W), .HANDLER_PC(HANDLER)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: privilege flag, a one-cycle pending redirect, halt flag, saved registers.
  bit          m_sup, m_redir, m_ret, m_halt;
  logic [31:0] m_target;
  logic [31:0] m_rm0, m_rm1, m_rm2;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sup <= 0; m_redir <= 0; m_ret <= 0; m_halt <= 0;
      m_target <= 0; m_rm0 <= 0; m_rm1 <= 0; m_rm2 <= 0;
    end else if (m_redir) begin
      m_redir <= 0;
      if (m_ret) begin
        m_sup <= 0;
        m_ret <= 0;
      end
    end else if (m_halt) begin
      m_halt <= 1;
    end else if (!m_sup) begin
      if (bus.in_commit_valid && bus.in_commit_exception_vector != 0) begin
        m_rm0    <= bus.in_commit_pc;
        m_rm1    <= bus.in_commit_exception_vector[0] ? bus.in_commit_fault_addr : bus.in_commit_pc;
        m_rm2    <= {29'b0, bus.in_commit_exception_vector};
        m_redir  <= 1;
        m_target <= HANDLER;
        m_sup    <= 1;
      end
    end else begin
      if (HALT_EN && bus.in_commit_valid && bus.in_commit_exception_vector != 0)
        m_halt <= 1;
      else if (bus.in_commit_valid && bus.in_commit_instr_type == INSTR_TYPE_IRET) begin
        m_redir  <= 1;
        m_ret    <= 1;
        m_target <= m_rm0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("sup_mode", 32'(bus.out_supervisor_mode), 32'(m_sup || m_halt));
      chk("flush", 32'(bus.out_flush), 32'(m_redir || m_halt));
      chk("redir_valid", 32'(bus.out_redirect_valid), 32'(m_redir));
      chk("redir_pc", bus.out_redirect_pc, m_redir ? m_target : 32'h0);
      chk("rm0", bus.out_rm0, m_rm0);
      chk("rm1", bus.out_rm1, m_rm1);
      chk("rm2", bus.out_rm2, m_rm2);
      chk("halted", 32'(bus.out_halted), 32'(m_halt));
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] typ,
                       input logic [2:0] vec, input logic [31:0] fa);
    bus.in_commit_valid            = v;
    bus.in_commit_pc               = pc;
    bus.in_commit_instr_type       = typ;
    bus.in_commit_exception_vector = vec;
    bus.in_commit_fault_addr       = fa;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, INSTR_TYPE_ALU, 3'b000, 32'h0);
  endtask

  // Reset pulse placed clear of both edges so the per-cycle compare never races it.
  task automatic pulse_reset();
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk); #2 reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_sup", 32'(bus.out_supervisor_mode), 32'h0);
    chk("reset_redir", 32'(bus.out_redirect_valid), 32'h0);
    chk("reset_rm0", bus.out_rm0, 32'h0);

    // Privileged op trap.
    drive(1, 32'h100, INSTR_TYPE_ALU, 3'b100, 32'hdead_beef);
    @(negedge clk);
    idle();
    chk("priv_flush", 32'(bus.out_flush), 32'h1);
    chk("priv_redir_pc", bus.out_redirect_pc, 32'h2000);
    chk("priv_rm0", bus.out_rm0, 32'h100);
    chk("priv_rm1", bus.out_rm1, 32'h100);
    chk("priv_rm2", bus.out_rm2, 32'h4);
    chk("priv_sup", 32'(bus.out_supervisor_mode), 32'h1);
    @(negedge clk);
    chk("super_flush", 32'(bus.out_flush), 32'h0);
    drive(1, 32'h2010, INSTR_TYPE_IRET, 3'b000, 32'h0);
    @(negedge clk);
    idle();
    chk("iret1_pc", bus.out_redirect_pc, 32'h100);
    @(negedge clk);
    chk("iret1_user", 32'(bus.out_supervisor_mode), 32'h0);

    // DTLB miss and return.
    drive(1, 32'h204, INSTR_TYPE_LOAD, 3'b001, 32'h8000_0010);
    @(negedge clk);
    idle();
    chk("dtlb_rm1", bus.out_rm1, 32'h8000_0010);
    chk("dtlb_rm2", bus.out_rm2, 32'h1);
    @(negedge clk);
    drive(1, 32'h2020, INSTR_TYPE_IRET, 3'b000, 32'h0);
    @(negedge clk);
    idle();
    chk("dtlb_ret_valid", 32'(bus.out_redirect_valid), 32'h1);
    chk("dtlb_ret_pc", bus.out_redirect_pc, 32'h204);
    @(negedge clk);
    chk("dtlb_user", 32'(bus.out_supervisor_mode), 32'h0);
    chk("dtlb_one_cycle", 32'(bus.out_redirect_valid), 32'h0);

    // IRET in user mode is a no-op.
    drive(1, 32'h400, INSTR_TYPE_IRET, 3'b000, 32'h0);
    @(negedge clk);
    idle();
    chk("uiret_flush", 32'(bus.out_flush), 32'h0);
    chk("uiret_redir", 32'(bus.out_redirect_valid), 32'h0);
    chk("uiret_rm0", bus.out_rm0, 32'h204);

    // Exception while in supervisor mode.
    drive(1, 32'h500, INSTR_TYPE_ALU, 3'b010, 32'h123);
    @(negedge clk);
    idle();
    @(negedge clk);
    drive(1, 32'h600, INSTR_TYPE_ALU, 3'b010, 32'h999);
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    chk("dbl_halted", 32'(bus.out_halted), HALT_EN ? 32'h1 : 32'h0);
    chk("dbl_flush", 32'(bus.out_flush), HALT_EN ? 32'h1 : 32'h0);
    chk("dbl_sup", 32'(bus.out_supervisor_mode), 32'h1);
    chk("dbl_rm0", bus.out_rm0, 32'h500);
    chk("dbl_rm2", bus.out_rm2, 32'h2);
    pulse_reset();
    @(negedge clk);
    chk("dbl_cleared", 32'(bus.out_halted), 32'h0);

    // Reset during the trap-entry redirect cycle.
    drive(1, 32'h700, INSTR_TYPE_ALU, 3'b100, 32'h0);
    @(posedge clk); #1;
    idle();
    chk("enter_redir", 32'(bus.out_redirect_valid), 32'h1);
    reset = 1'b1;
    #1;
    chk("rst_enter_redir", 32'(bus.out_redirect_valid), 32'h0);
    chk("rst_enter_sup", 32'(bus.out_supervisor_mode), 32'h0);
    chk("rst_enter_rm0", bus.out_rm0, 32'h0);
    @(negedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_no_strobe", 32'(bus.out_redirect_valid), 32'h0);

    // Randomized commits checked every cycle by the model compare.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else begin
        drive($urandom_range(0, 9) < 7,
              32'($urandom_range(0, 32'hffff)) << 2,
              ($urandom_range(0, 9) < 3) ? INSTR_TYPE_IRET : 3'($urandom_range(0, 4)),
              ($urandom_range(0, 9) < 2) ? 3'($urandom_range(1, 7)) : 3'b000,
              $urandom);
      end
    end
    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
